// File: rtl/spi_slave.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first, 8-bit words), oversampled by clk.
// MOSI bytes land in rx_data; MISO shifts out a byte preloaded through a holding register.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_active
);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [7:0] hold, tx_shift, next_byte;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       armed, byte_done, byte_start;

  // cs synchronizer clears low so a frame already running at reset release
  // produces no falling strobe and stays ignored until cs rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (cs_fall) state_next = SHIFT;
      SHIFT: if (cs_rise) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign next_byte  = tx_ready ? IDLE_BYTE : hold;
  assign byte_start = ((state == IDLE) && cs_fall) ||
                      ((state == SHIFT) && sclk_fall && armed && byte_done);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      tx_ready  <= 1'b1;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      bit_cnt   <= '0;
      armed     <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // A load coinciding with a byte start is accepted: the transfer uses the old contents.
      if (tx_load && (tx_ready || byte_start)) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end else if (byte_start) begin
        tx_ready <= 1'b1;
      end

      if (byte_start) tx_shift <= next_byte;

      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            armed     <= 1'b0;
            byte_done <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            armed     <= 1'b0;
            byte_done <= 1'b0;
            bit_cnt   <= '0;
          end else begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[5:0], mosi_s};
              bit_cnt  <= bit_cnt + 3'd1;
              armed    <= 1'b1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= {rx_shift, mosi_s};
                rx_valid  <= 1'b1;
                byte_done <= 1'b1;
              end
            end
            if (sclk_fall && armed) begin
              if (byte_done) byte_done <= 1'b0;
              else           tx_shift  <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign miso         = (state == SHIFT) & tx_shift[7];
  assign frame_active = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged mode-0 master drives the link,
// received bytes are queued as expectations and checked by a separate rx monitor.
module tb_spi_slave;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset, sclk, cs, mosi, miso;
  logic [7:0] tx_data, rx_data;
  logic       tx_load, tx_ready, rx_valid, frame_active;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       rx_valid_prev = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_active(frame_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      check("rx_valid_width", {31'd0, rx_valid_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rx: got rx_data %0h expected no rx_valid at %0t", rx_data, $time);
      end else begin
        check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    rx_valid_prev = rx_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    wait_clks(HALF);
    sclk = 1'b1;
    s = miso;
    wait_clks(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_start();
    cs = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_end();
    wait_clks(HALF);
    cs = 1'b1;
    wait_clks(2 * HALF);
  endtask

  task automatic preload(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 200) begin
      wait_clks(1);
      n++;
    end
    check("preload_ready", {31'd0, tx_ready}, 32'd1);
    tx_data = d;
    tx_load = 1'b1;
    wait_clks(1);
    tx_load = 1'b0;
    check("preload_taken", {31'd0, tx_ready}, 32'd0);
  endtask

  initial begin
    logic [7:0] r, r1, r2, r3;
    logic       b;
    reset = 1'b0; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; tx_load = 1'b0; tx_data = '0;
    wait_clks(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_frame_active", {31'd0, frame_active}, 32'd0);
    reset = 1'b1;
    wait_clks(5);

    // single byte with preload
    preload(8'hA5);
    exp_q.push_back(8'h3C);
    cs_start();
    check("t1_frame_active", {31'd0, frame_active}, 32'd1);
    spi_byte(8'h3C, r);
    cs_end();
    check("t1_miso_byte", {24'd0, r}, 32'hA5);
    check("t1_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t1_rx_data", {24'd0, rx_data}, 32'h3C);
    check("t1_frame_idle", {31'd0, frame_active}, 32'd0);

    // no preload: idle byte
    exp_q.push_back(8'h00);
    cs_start();
    spi_byte(8'h00, r);
    cs_end();
    check("t2_miso_idle", {24'd0, r}, 32'hFF);
    check("t2_rx_data", {24'd0, rx_data}, 32'h00);

    // three-byte continuous frame
    preload(8'h11);
    exp_q.push_back(8'h5E);
    exp_q.push_back(8'h7B);
    exp_q.push_back(8'hE4);
    cs_start();
    preload(8'h22);
    spi_byte(8'h5E, r1);
    preload(8'h33);
    spi_byte(8'h7B, r2);
    spi_byte(8'hE4, r3);
    cs_end();
    check("t3_miso_b0", {24'd0, r1}, 32'h11);
    check("t3_miso_b1", {24'd0, r2}, 32'h22);
    check("t3_miso_b2", {24'd0, r3}, 32'h33);

    // partial frame discarded, then a full one
    cs_start();
    spi_bit(1'b1, b); spi_bit(1'b0, b); spi_bit(1'b1, b); spi_bit(1'b1, b); spi_bit(1'b0, b);
    cs_end();
    check("t4_rx_kept", {24'd0, rx_data}, 32'hE4);
    exp_q.push_back(8'h5A);
    cs_start();
    spi_byte(8'h5A, r);
    cs_end();
    check("t4_rx_data", {24'd0, rx_data}, 32'h5A);
    check("t4_miso_idle", {24'd0, r}, 32'hFF);

    // sclk idling high: leading falling edge must not shift
    sclk = 1'b1;
    wait_clks(6);
    preload(8'h81);
    exp_q.push_back(8'h42);
    cs = 1'b0;
    wait_clks(HALF);
    sclk = 1'b0;
    wait_clks(HALF);
    spi_byte(8'h42, r);
    cs_end();
    check("t5_miso_byte", {24'd0, r}, 32'h81);

    // reset mid-frame after bit 4
    cs_start();
    spi_bit(1'b1, b); spi_bit(1'b1, b); spi_bit(1'b0, b); spi_bit(1'b0, b);
    preload(8'h99);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_miso", {31'd0, miso}, 32'd0);
    check("t6_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t6_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("t6_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("t6_rst_frame_active", {31'd0, frame_active}, 32'd0);
    wait_clks(3);
    reset = 1'b1;
    spi_bit(1'b0, b); spi_bit(1'b0, b); spi_bit(1'b1, b); spi_bit(1'b1, b);
    check("t6_ignored_frame", {31'd0, frame_active}, 32'd0);
    cs_end();
    check("t6_rx_after", {24'd0, rx_data}, 32'd0);
    exp_q.push_back(8'hC3);
    cs_start();
    spi_byte(8'hC3, r);
    cs_end();
    check("t6_rx_data", {24'd0, rx_data}, 32'hC3);
    check("t6_miso_idle", {24'd0, r}, 32'hFF);

    wait_clks(20);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
